// File: rtl/vpu_dst_port.sv
// VPU destination port: buffers ALU results and writes them to SRAM.
// Define VPU_DST_PORT_OVF_FLAG_EN to enable the sticky ovf_o flag.
module vpu_dst_port #(
  parameter int OPCODE_WIDTH = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int LEN_WIDTH    = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  input  logic [OPCODE_WIDTH-1:0] result_i,
  input  logic                    result_done_i,
  output logic                    wr_valid_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [OPCODE_WIDTH-1:0] wr_data_o,
  input  logic                    wr_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ovf_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [CW-1:0]           len_q;
  logic [CW-1:0]           in_cnt_q;
  logic [CW-1:0]           out_cnt_q;
  logic                    busy_q;
  logic                    done_q;

  logic [OPCODE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [PW:0]             cnt_q;

  logic empty;
  logic full;
  logic pop;
  logic req;
  logic push;
  logic last;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop   = !empty && wr_ready_i;
  assign req   = (state_q == S_RUN) && result_done_i
              && (in_cnt_q < len_q);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push  = req && (!full || pop);
  assign last  = pop && ((out_cnt_q + CW'(1)) == len_q);

  assign wr_valid_o = !empty;
  assign wr_data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign wr_addr_o  = base_q + ADDR_WIDTH'(out_cnt_q);
  assign busy_o     = busy_q;
  assign done_o     = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) in_cnt_q <= in_cnt_q + CW'(1);
      if (pop)  out_cnt_q <= out_cnt_q + CW'(1);
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            base_q    <= base_addr_i;
            len_q     <= {1'b0, len_i};
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            if (len_i == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (last) begin
            state_q <= S_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= result_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef VPU_DST_PORT_OVF_FLAG_EN
  logic ovf_q;
  logic drop;

  assign drop  = req && full && !pop;
  assign ovf_o = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start_i) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_vpu_dst_port.sv
// Randomised and directed bench for vpu_dst_port.
// Queue-based reference model checked on every falling edge.
module tb_vpu_dst_port;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int LW    = 10;
  localparam int DEPTH = 4;
`ifdef VPU_DST_PORT_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic [DW-1:0] result_i = '0;
  logic          result_done_i = 1'b0;
  logic          wr_ready_i = 1'b0;
  logic          wr_valid_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic          ovf_o;

  vpu_dst_port #(
    .OPCODE_WIDTH(DW),
    .ADDR_WIDTH  (AW),
    .LEN_WIDTH   (LW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .result_i     (result_i),
    .result_done_i(result_done_i),
    .wr_valid_o   (wr_valid_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .wr_ready_i   (wr_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 finishing
  int            m_phase = 0;
  int            m_base = 0;
  int            m_len = 0;
  int            m_in = 0;
  int            m_out = 0;
  bit            m_ovf = 1'b0;
  logic [DW-1:0] mq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_base  = 0;
      m_len   = 0;
      m_in    = 0;
      m_out   = 0;
      m_ovf   = 1'b0;
      mq.delete();
    end else begin
      bit pop, req, acc;
      pop = (mq.size() > 0) && wr_ready_i;
      req = (m_phase == 1) && result_done_i && (m_in < m_len);
      acc = req && ((mq.size() < DEPTH) || pop);
      if (pop) begin
        void'(mq.pop_front());
        m_out++;
      end
      if (acc) begin
        mq.push_back(result_i);
        m_in++;
      end
      if (req && !acc) m_ovf = 1'b1;
      case (m_phase)
        0: if (start_i) begin
          m_base  = int'(base_addr_i);
          m_len   = int'(len_i);
          m_in    = 0;
          m_out   = 0;
          m_ovf   = 1'b0;
          m_phase = (len_i == 0) ? 2 : 1;
        end
        1: if (m_out == m_len) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("valid", wr_valid_o, mq.size() > 0);
      if (mq.size() > 0) begin
        check("addr", wr_addr_o, (m_base + m_out) % (1 << AW));
        check("data", wr_data_o, mq[0]);
      end
      check("busy", busy_o, m_phase == 1);
      check("done", done_o, m_phase == 2);
      check("ovf", ovf_o, OVF_EN && m_ovf);
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t log_q[$];
  int  cyc = 0;

  always @(posedge clk) begin
    if (!rst && wr_valid_o && wr_ready_i)
      log_q.push_back('{wr_addr_o, wr_data_o, cyc});
    cyc++;
  end

  task automatic start(input int b, input int l);
    @(negedge clk);
    start_i     = 1'b1;
    base_addr_i = AW'(b);
    len_i       = LW'(l);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] v);
    result_i      = v;
    result_done_i = 1'b1;
    @(negedge clk);
    result_done_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, done_o, 1);
  endtask

  task automatic check_wr(input string nm, input int idx,
                          input int a, input logic [DW-1:0] d);
    if (idx < log_q.size()) begin
      check({nm, "_addr"}, log_q[idx].addr, a);
      check({nm, "_data"}, log_q[idx].data, d);
    end else begin
      check({nm, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    check("rst_valid", wr_valid_o, 0);
    check("rst_addr", wr_addr_o, 0);
    check("rst_data", wr_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ovf", ovf_o, 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // basic write-back
    wr_ready_i = 1'b1;
    n0 = log_q.size();
    start(32'h010, 3);
    push(32'hA);
    push(32'hB);
    push(32'hC);
    wait_done("t1_done", 20);
    check("t1_cnt", log_q.size() - n0, 3);
    check_wr("t1_w0", n0, 32'h010, 32'hA);
    check_wr("t1_w1", n0 + 1, 32'h011, 32'hB);
    check_wr("t1_w2", n0 + 2, 32'h012, 32'hC);
    if (log_q.size() - n0 == 3) begin
      check("t1_consec", log_q[n0+2].cyc - log_q[n0].cyc, 2);
      check("t1_done_lat", cyc, log_q[n0+2].cyc + 1);
    end
    @(negedge clk);
    check("t1_done_pulse", done_o, 0);

    // backpressure
    wr_ready_i = 1'b0;
    n0 = log_q.size();
    start(32'h100, 4);
    push(32'h11);
    push(32'h22);
    push(32'h33);
    push(32'h44);
    repeat (2) @(negedge clk);
    check("t2_hold_valid", wr_valid_o, 1);
    check("t2_hold_addr", wr_addr_o, 32'h100);
    check("t2_hold_data", wr_data_o, 32'h11);
    wr_ready_i = 1'b1;
    wait_done("t2_done", 20);
    check_wr("t2_w0", n0, 32'h100, 32'h11);
    check_wr("t2_w3", n0 + 3, 32'h103, 32'h44);
    check("t2_ovf", ovf_o, 0);

    // address wrap
    n0 = log_q.size();
    start(32'h3FE, 4);
    push(32'h1);
    push(32'h2);
    push(32'h3);
    push(32'h4);
    wait_done("t3_done", 20);
    check_wr("t3_w0", n0, 32'h3FE, 32'h1);
    check_wr("t3_w1", n0 + 1, 32'h3FF, 32'h2);
    check_wr("t3_w2", n0 + 2, 32'h000, 32'h3);
    check_wr("t3_w3", n0 + 3, 32'h001, 32'h4);

    // zero length, pushes while idle
    n0 = log_q.size();
    start(32'h055, 0);
    check("t4_done", done_o, 1);
    check("t4_valid", wr_valid_o, 0);
    push(32'hDEAD);
    push(32'hBEEF);
    push(32'hCAFE);
    @(negedge clk);
    check("t4_nowrite", log_q.size() - n0, 0);

    // overflow
    wr_ready_i = 1'b0;
    n0 = log_q.size();
    start(32'h020, 8);
    for (int i = 1; i <= 6; i++) push(DW'(32'h50 + i));
    check("t5_valid", wr_valid_o, 1);
    check("t5_ovf", ovf_o, OVF_EN);
    wr_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_buffered", log_q.size() - n0, 4);
    check_wr("t5_w3", n0 + 3, 32'h023, 32'h54);
    check("t5_busy", busy_o, 1);
    check("t5_ovf_sticky", ovf_o, OVF_EN);
    for (int i = 7; i <= 10; i++) push(DW'(32'h50 + i));
    wait_done("t5_done", 20);
    check_wr("t5_w4", n0 + 4, 32'h024, 32'h57);

    // reset mid-operation
    wr_ready_i = 1'b0;
    start(32'h200, 5);
    push(32'h1);
    push(32'h2);
    check("t6_pre_valid", wr_valid_o, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", wr_valid_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_done", done_o, 0);
    @(negedge clk);
    rst        = 1'b0;
    wr_ready_i = 1'b1;
    n0 = log_q.size();
    start(32'h0AB, 1);
    push(32'h77);
    wait_done("t6_done", 20);
    check("t6_cnt", log_q.size() - n0, 1);
    check_wr("t6_w0", n0, 32'h0AB, 32'h77);

    // randomised vectors
    for (int it = 0; it < 25; it++) begin
      int n;
      start($urandom_range(0, 1023), $urandom_range(0, 10));
      n = 0;
      while (!done_o && n < 400) begin
        result_done_i = ($urandom_range(0, 2) != 0);
        result_i      = $urandom;
        wr_ready_i    = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        n++;
      end
      result_done_i = 1'b0;
      check("rand_done", done_o, 1);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
